// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the ID-stage register file and its debug dump
// engine: data/address widths, register count, dump FSM state encoding and
// a small helper for detecting the final register index.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int NB_DATA = 32;            // register/data width
    localparam int NB_REG  = 5;             // register address width
    localparam int N_REGS  = 2 ** NB_REG;   // number of architectural registers

    // Dump engine states. The encoding is visible to the debug unit
    // tooling, so the values are fixed explicitly.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } dump_state_e;

    // True when addr is the highest register index (end of a dump).
    function automatic logic is_last_reg(input logic [NB_REG-1:0] addr);
        return (addr == NB_REG'(N_REGS - 1));
    endfunction

endpackage : cpu_pkg

// File: rtl/register_dump_ctrl.sv
// ---------------------------------------------------------------------------
// register_dump_ctrl
// Sequencer for the register-file debug dump. Walks register indices
// 0..N_REGS-1 over a valid/ready handshake and asks the register bank to
// capture the next beat's data through a load strobe + read address.
//
// Ports
//   i_clock       in   system clock, rising edge
//   i_reset       in   synchronous reset, active-low
//   i_dump_start  in   dump request (level, only honoured in IDLE)
//   i_dump_ready  in   debug unit accepts the current beat
//   o_dump_valid  out  current beat valid (registered)
//   o_dump_addr   out  register index of current beat (registered)
//   o_dump_done   out  one-cycle pulse after the last beat (registered)
//   o_load        out  capture reg[o_load_addr] into the beat data register
//   o_load_addr   out  register index to capture on o_load
// ---------------------------------------------------------------------------
module register_dump_ctrl
    import cpu_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_dump_start,
    input  logic              i_dump_ready,
    output logic              o_dump_valid,
    output logic [NB_REG-1:0] o_dump_addr,
    output logic              o_dump_done,
    output logic              o_load,
    output logic [NB_REG-1:0] o_load_addr
);

    dump_state_e       state_r;
    dump_state_e       state_s;
    logic [NB_REG-1:0] addr_r;
    logic [NB_REG-1:0] addr_s;
    logic              valid_r;
    logic              valid_s;
    logic              done_r;
    logic              done_s;
    logic              load_s;
    logic [NB_REG-1:0] load_addr_s;

    // Next-state, counter and load-strobe decode for the dump sequencer.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        valid_s     = valid_r;
        done_s      = 1'b0;
        load_s      = 1'b0;
        load_addr_s = addr_r;

        case (state_r)
            ST_IDLE: begin
                if (i_dump_start) begin
                    state_s     = ST_DUMP;
                    addr_s      = '0;
                    valid_s     = 1'b1;
                    load_s      = 1'b1;
                    load_addr_s = '0;
                end else begin
                    state_s     = ST_IDLE;
                end
            end

            ST_DUMP: begin
                if (valid_r && i_dump_ready) begin
                    if (is_last_reg(addr_r)) begin
                        // Last beat accepted: drop valid; address does not wrap.
                        valid_s = 1'b0;
                        state_s = ST_DONE;
                    end else begin
                        addr_s      = addr_r + NB_REG'(1);
                        load_s      = 1'b1;
                        load_addr_s = addr_r + NB_REG'(1);
                    end
                end else begin
                    // Backpressure: hold the presented beat unchanged.
                    state_s = ST_DUMP;
                end
            end

            ST_DONE: begin
                // done is registered, so it becomes visible in the cycle
                // after DONE, while the FSM is already back in IDLE.
                state_s = ST_IDLE;
                done_s  = 1'b1;
            end

            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered handshake outputs.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            valid_r <= valid_s;
            done_r  <= done_s;
        end
    end

    assign o_dump_valid = valid_r;
    assign o_dump_addr  = addr_r;
    assign o_dump_done  = done_r;
    assign o_load       = load_s;
    assign o_load_addr  = load_addr_s;

endmodule : register_dump_ctrl

// File: rtl/id_register_bank.sv
// ---------------------------------------------------------------------------
// id_register_bank
// Architectural register file of the MIPS pipeline. One write port from the
// WB stage, two combinational read ports for ID with a same-cycle WB->ID
// bypass, and a debug dump engine that streams every register out over a
// valid/ready handshake. r0 is hard-wired to zero.
//
// Ports
//   i_clock             in   system clock, rising edge
//   i_reset             in   synchronous reset, active-low
//   i_enable            in   pipeline enable; gates WB writes
//   i_WB_reg_write      in   WB write strobe
//   i_WB_selected_reg   in   WB write address
//   i_WB_selected_data  in   WB write data
//   i_ID_rs / i_ID_rt   in   read addresses A / B
//   o_ID_data_a / _b    out  read data A / B (combinational, bypassed)
//   i_dump_start        in   request full register dump
//   i_dump_ready        in   debug unit accepts current beat
//   o_dump_valid        out  beat valid
//   o_dump_addr         out  register index of current beat
//   o_dump_data         out  snapshot of that register
//   o_dump_done         out  one-cycle pulse after the last beat
// ---------------------------------------------------------------------------
module id_register_bank
    import cpu_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_WB_reg_write,
    input  logic [NB_REG-1:0]  i_WB_selected_reg,
    input  logic [NB_DATA-1:0] i_WB_selected_data,
    input  logic [NB_REG-1:0]  i_ID_rs,
    input  logic [NB_REG-1:0]  i_ID_rt,
    output logic [NB_DATA-1:0] o_ID_data_a,
    output logic [NB_DATA-1:0] o_ID_data_b,
    input  logic               i_dump_start,
    input  logic               i_dump_ready,
    output logic               o_dump_valid,
    output logic [NB_REG-1:0]  o_dump_addr,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_done
);

    logic [NB_DATA-1:0] reg_array_r [N_REGS];
    logic [NB_DATA-1:0] dump_data_r;
    logic               wr_en_s;
    logic               load_s;
    logic [NB_REG-1:0]  load_addr_s;

    // A write is architecturally visible only when the pipeline is enabled
    // and the target is not r0.
    assign wr_en_s = i_enable & i_WB_reg_write & (i_WB_selected_reg != '0);

    // Operand read: r0 is zero, a write landing this cycle is forwarded,
    // otherwise the stored value.
    function automatic logic [NB_DATA-1:0] read_operand(input logic [NB_REG-1:0] addr);
        logic [NB_DATA-1:0] value;
        if (addr == '0) begin
            value = '0;
        end else if (wr_en_s && (addr == i_WB_selected_reg)) begin
            value = i_WB_selected_data;
        end else begin
            value = reg_array_r[addr];
        end
        return value;
    endfunction

    // ID operand read ports with WB bypass.
    always_comb begin
        o_ID_data_a = read_operand(i_ID_rs);
        o_ID_data_b = read_operand(i_ID_rt);
    end

    // Register array: cleared on reset, written from WB.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                reg_array_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            reg_array_r[i_WB_selected_reg] <= i_WB_selected_data;
        end else begin
            reg_array_r <= reg_array_r;
        end
    end

    // Dump beat data: captured from the array (no bypass) only when the
    // sequencer advances, so WB writes to the presented register leave the
    // beat untouched.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            dump_data_r <= '0;
        end else if (load_s) begin
            dump_data_r <= reg_array_r[load_addr_s];
        end else begin
            dump_data_r <= dump_data_r;
        end
    end

    register_dump_ctrl u_dump_ctrl (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_dump_valid (o_dump_valid),
        .o_dump_addr  (o_dump_addr),
        .o_dump_done  (o_dump_done),
        .o_load       (load_s),
        .o_load_addr  (load_addr_s)
    );

    assign o_dump_data = dump_data_r;

endmodule : id_register_bank
